// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg
//   Shared constants, the stored node record and the component selector for
//   the depth-6 KD-tree internal node pipeline.
//   Contents:
//     DSIZE, NUM_DIMS, TREE_DEPTH, NUM_NODES  tree geometry
//     node_t                                  {signed median, 3-bit split dim}
//     get_component(patch, dim)               pick one 11-bit signed component
package kd_tree_pkg;

   localparam int DSIZE      = 11;
   localparam int NUM_DIMS   = 5;
   localparam int TREE_DEPTH = 6;
   localparam int NUM_NODES  = 63;

   typedef struct packed {
      logic signed [DSIZE-1:0] median;
      logic        [2:0]       dim;
   } node_t;

   // Component k lives at [54-11k -: 11]; any dim outside 0..4 falls back to component 0.
   function automatic logic signed [DSIZE-1:0] get_component(
      input logic [NUM_DIMS*DSIZE-1:0] patch,
      input logic [2:0]                dim
   );
      logic signed [DSIZE-1:0] comp;
      case (dim)
         3'd1:    comp = patch[43:33];
         3'd2:    comp = patch[32:22];
         3'd3:    comp = patch[21:11];
         3'd4:    comp = patch[10:0];
         default: comp = patch[54:44];
      endcase
      return comp;
   endfunction

endpackage

// File: rtl/kd_tree_level_stage.sv
// kd_tree_level_stage
//   One level of the KD-tree walk. The incoming position is an offset within
//   this level (node index = 2^LEVEL - 1 + offset). The stage selects that
//   node, compares the chosen patch component with its median and registers
//   the offset of the child within the next level: 2*offset (left) or
//   2*offset+1 (right). At the last level this offset is the leaf number.
// Ports
//   clk            in   clock
//   wrst_n         in   synchronous active-low reset
//   i_level_nodes  in   the 2^LEVEL nodes of this level, entry k = offset k
//   i_offset       in   offset of the current node within this level
//   i_patch        in   query patch travelling with this offset
//   o_offset       out  registered child offset within the next level
//   o_patch        out  patch for the next level (registered when PATCH_REG_EN)
module kd_tree_level_stage
   import kd_tree_pkg::*;
#(
   parameter int LEVEL        = 0,
   parameter bit PATCH_REG_EN = 1'b1
) (
   input  logic                            clk,
   input  logic                            wrst_n,
   input  node_t [(1<<LEVEL)-1:0]          i_level_nodes,
   input  logic [5:0]                      i_offset,
   input  logic [NUM_DIMS*DSIZE-1:0]       i_patch,
   output logic [5:0]                      o_offset,
   output logic [NUM_DIMS*DSIZE-1:0]       o_patch
);

   localparam int N = 1 << LEVEL;

   node_t                   w_node;
   logic signed [DSIZE-1:0] w_comp;
   logic                    w_go_left;
   logic [5:0]              w_next_offset;
   logic [5:0]              r_offset;

   // Node read mux, signed compare and child offset; equal medians go right
   always_comb begin
      w_node = '0;
      for (int k = 0; k < N; k++) begin
         w_node = (i_offset == 6'(k)) ? i_level_nodes[k] : w_node;
      end
      w_comp        = get_component(i_patch, w_node.dim);
      w_go_left     = ($signed(w_comp) < $signed(w_node.median));
      w_next_offset = 6'({i_offset, 1'b0}) | {5'd0, ~w_go_left};
   end

   // Child offset register
   always_ff @(posedge clk) begin
      if (!wrst_n) begin
         r_offset <= 6'd0;
      end else begin
         r_offset <= w_next_offset;
      end
   end

   assign o_offset = r_offset;

   if (PATCH_REG_EN) begin : g_patch_reg
      logic [NUM_DIMS*DSIZE-1:0] r_patch;

      // Patch copy that follows the offset into the next level
      always_ff @(posedge clk) begin
         if (!wrst_n) begin
            r_patch <= '0;
         end else begin
            r_patch <= i_patch;
         end
      end

      assign o_patch = r_patch;
   end else begin : g_patch_pass
      assign o_patch = i_patch;
   end

endmodule

// File: rtl/kd_internal_node_tree.sv
// kd_internal_node_tree
//   Holds the 63 internal nodes (split dim + median) of a depth-6 KD tree in
//   heap order and walks one 5-component query patch per cycle from the root
//   to one of 64 leaves through a 6-stage pipeline (latency 6 edges).
//   Optional feature macro: KD_PATCH_OUT_EN adds patch_out, the query patch
//   delayed to line up with leaf_index.
// Ports
//   clk            in   clock
//   wrst_n         in   synchronous active-low reset
//   fsm_enable     in   load phase enable
//   sender_enable  in   node word valid on sender_data
//   sender_data    in   {median[21:11] signed, dim[10:0] (low 3 bits used)}
//   patch_in       in   component k at [54-11k -: 11], two's complement
//   leaf_index     out  leaf reached, zero-extended 0..63, registered
//   patch_out      out  (KD_PATCH_OUT_EN only) patch aligned with leaf_index
module kd_internal_node_tree
   import kd_tree_pkg::*;
#(
   parameter int INTERNAL_WIDTH = 22,
   parameter int PATCH_WIDTH    = 55,
   parameter int ADDRESS_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      wrst_n,
   input  logic                      fsm_enable,
   input  logic                      sender_enable,
   input  logic [INTERNAL_WIDTH-1:0] sender_data,
   input  logic [PATCH_WIDTH-1:0]    patch_in,
   output logic [ADDRESS_WIDTH-1:0]  leaf_index
`ifdef KD_PATCH_OUT_EN
   ,
   output logic [PATCH_WIDTH-1:0]    patch_out
`endif
);

`ifdef KD_PATCH_OUT_EN
   localparam bit LAST_PATCH_REG = 1'b1;
`else
   localparam bit LAST_PATCH_REG = 1'b0;
`endif

   node_t [NUM_NODES-1:0]  r_nodes;
   logic  [5:0]            r_count;
   node_t                  w_wr_node;
   logic  [DSIZE-4:0]      w_unused_dim_hi;

   logic [5:0]             w_offset [0:TREE_DEPTH];
   logic [PATCH_WIDTH-1:0] w_patch  [0:TREE_DEPTH];

   assign w_wr_node.median = sender_data[INTERNAL_WIDTH-1 -: DSIZE];
   assign w_wr_node.dim    = sender_data[2:0];
   assign w_unused_dim_hi  = sender_data[DSIZE-1:3];

   // Node table and load counter; the counter parks at 63 so later words are dropped
   always_ff @(posedge clk) begin
      if (!wrst_n) begin
         r_nodes <= '0;
         r_count <= 6'd0;
      end else if (fsm_enable && sender_enable && (r_count != 6'(NUM_NODES))) begin
         r_nodes[r_count] <= w_wr_node;
         r_count          <= r_count + 6'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign w_offset[0] = 6'd0;
   assign w_patch[0]  = patch_in;

   for (genvar gl = 0; gl < TREE_DEPTH; gl++) begin : g_level
      localparam int N = 1 << gl;

      // Level gl owns heap nodes [2^gl - 1 .. 2^(gl+1) - 2]
      kd_tree_level_stage #(
         .LEVEL        (gl),
         .PATCH_REG_EN ((gl < TREE_DEPTH-1) ? 1'b1 : LAST_PATCH_REG)
      ) u_stage (
         .clk           (clk),
         .wrst_n        (wrst_n),
         .i_level_nodes (r_nodes[2*N-2 -: N]),
         .i_offset      (w_offset[gl]),
         .i_patch       (w_patch[gl]),
         .o_offset      (w_offset[gl+1]),
         .o_patch       (w_patch[gl+1])
      );
   end

   // Offset after the last level is the leaf number (child index minus 63)
   assign leaf_index = {{(ADDRESS_WIDTH-6){1'b0}}, w_offset[TREE_DEPTH]};

`ifdef KD_PATCH_OUT_EN
   assign patch_out = w_patch[TREE_DEPTH];
`else
   logic [PATCH_WIDTH-1:0] w_unused_patch;
   assign w_unused_patch = w_patch[TREE_DEPTH];
`endif

endmodule

// File: tb/tb_kd_internal_node_tree.sv
module tb_kd_internal_node_tree;

   logic        clk = 1'b0;
   logic        wrst_n;
   logic        fsm_enable;
   logic        sender_enable;
   logic [21:0] sender_data;
   logic [54:0] patch_in;
   logic [7:0]  leaf_index;
`ifdef KD_PATCH_OUT_EN
   logic [54:0] patch_out;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [10:0] m_med [0:62];
   int                 m_dim [0:62];
   logic [54:0]        rnd_p [0:19];
   int                 rnd_e [0:19];
   logic [54:0]        p_m1;
   logic [54:0]        p_0;

   always #5 clk = ~clk;

   kd_internal_node_tree dut (
      .clk           (clk),
      .wrst_n        (wrst_n),
      .fsm_enable    (fsm_enable),
      .sender_enable (sender_enable),
      .sender_data   (sender_data),
      .patch_in      (patch_in),
      .leaf_index    (leaf_index)
`ifdef KD_PATCH_OUT_EN
      ,
      .patch_out     (patch_out)
`endif
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [54:0] mk_patch(input int c0, input int c1, input int c2,
                                            input int c3, input int c4);
      return {11'(c0), 11'(c1), 11'(c2), 11'(c3), 11'(c4)};
   endfunction

   function automatic int rv();
      return int'($urandom_range(300, 0)) - 150;
   endfunction

   // Reference walk in heap indices: left child 2n+1, right 2n+2
   function automatic int model_leaf(input logic [54:0] p);
      int                 n;
      int                 d;
      logic signed [10:0] c;
      n = 0;
      for (int l = 0; l < 6; l++) begin
         d = m_dim[n];
         if (d >= 5) c = p[54:44];
         else        c = p[54-11*d -: 11];
         if (c < m_med[n]) n = 2*n + 1;
         else              n = 2*n + 2;
      end
      return n - 63;
   endfunction

   task automatic send_word(input int med, input int dim);
      sender_data   = {11'(med), 11'(dim)};
      sender_enable = 1'b1;
      step();
      sender_enable = 1'b0;
   endtask

   task automatic do_reset();
      wrst_n        = 1'b0;
      fsm_enable    = 1'b0;
      sender_enable = 1'b0;
      repeat (4) step();
      check_val("reset_leaf", 64'(leaf_index), 64'd0);
      wrst_n = 1'b1;
   endtask

   task automatic leaf_for(input logic [54:0] p, input string tag, input int exp);
      patch_in = p;
      repeat (6) step();
      check_val(tag, 64'(leaf_index), 64'(exp));
`ifdef KD_PATCH_OUT_EN
      check_val({tag, "_patch_out"}, 64'(patch_out), 64'(p));
`endif
   endtask

   initial begin
      wrst_n        = 1'b0;
      fsm_enable    = 1'b0;
      sender_enable = 1'b0;
      sender_data   = 22'd0;
      patch_in      = 55'd0;
      p_m1          = mk_patch(-1, 0, 0, 0, 0);
      p_0           = mk_patch(0, 0, 0, 0, 0);

      // Reset, then fill all 63 nodes with {median 0, dim 0}
      do_reset();
      fsm_enable = 1'b1;
      for (int i = 0; i < 63; i++) send_word(0, 0);
      fsm_enable = 1'b0;
      leaf_for(p_m1, "zero_neg1", 0);
      leaf_for(p_0, "zero_eq", 63);
      leaf_for(mk_patch(5, 0, 0, 0, 0), "zero_pos5", 63);
      leaf_for(mk_patch(-1024, 0, 0, 0, 0), "zero_min", 0);
      leaf_for(mk_patch(1023, 0, 0, 0, 0), "zero_max", 63);
      leaf_for(mk_patch(-1, 1023, -1024, 7, 7), "zero_other_comps", 0);

      // One patch per cycle, alternating; each result appears 6 edges later
      for (int j = 0; j < 16; j++) begin
         patch_in = (j % 2 == 0) ? p_m1 : p_0;
         step();
         if (j >= 5) check_val("alternate", 64'(leaf_index), ((j - 5) % 2 == 0) ? 64'd0 : 64'd63);
      end

      // Mixed dataset (dims 5/6 fall back to component 0), streamed random patches
      for (int i = 0; i < 63; i++) begin
         m_med[i] = 11'(((i * 37) % 201) - 100);
         m_dim[i] = i % 7;
      end
      do_reset();
      fsm_enable = 1'b1;
      for (int i = 0; i < 63; i++) send_word(int'(m_med[i]), m_dim[i]);
      fsm_enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rnd_p[i] = mk_patch(rv(), rv(), rv(), rv(), rv());
         rnd_e[i] = model_leaf(rnd_p[i]);
      end
      for (int j = 0; j < 25; j++) begin
         if (j < 20) patch_in = rnd_p[j];
         step();
         if (j >= 5) check_val("dataset_stream", 64'(leaf_index), 64'(rnd_e[j-5]));
      end
      leaf_for(p_0, "dataset_zero", model_leaf(p_0));

      // Gated words, then 63 real words, then 7 words past saturation
      do_reset();
      fsm_enable = 1'b0;
      for (int i = 0; i < 10; i++) send_word(500, 0);
      fsm_enable = 1'b1;
      for (int i = 0; i < 63; i++) send_word(0, 0);
      for (int i = 0; i < 7; i++) send_word(500, 0);
      fsm_enable = 1'b0;
      for (int i = 0; i < 5; i++) send_word(500, 0);
      leaf_for(p_0, "sat_eq", 63);
      leaf_for(p_m1, "sat_neg1", 0);
      leaf_for(mk_patch(499, 0, 0, 0, 0), "sat_499", 63);

      // Root splits on component 4, everything below on component 0
      do_reset();
      fsm_enable = 1'b1;
      send_word(10, 4);
      for (int i = 0; i < 62; i++) send_word(0, 0);
      fsm_enable = 1'b0;
      leaf_for(mk_patch(0, 0, 0, 0, 9), "dim4_lt", 31);
      check_val("dim4_left_half", 64'(leaf_index < 8'd32), 64'd1);
      leaf_for(mk_patch(0, 0, 0, 0, 10), "dim4_eq", 63);
      leaf_for(mk_patch(-1, 0, 0, 0, 9), "dim4_all_left", 0);

      // Reset clears the node table: same patch now goes all right
      patch_in = mk_patch(0, 0, 0, 0, 9);
      do_reset();
      leaf_for(mk_patch(0, 0, 0, 0, 9), "post_reset", 63);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
